// File: rtl/hall_pkg.sv
// hall_pkg: shared state encoding, default sizes and width helper for the Hall slice tracker.
package hall_pkg;

    localparam int SLICES_DEF = 128;
    localparam int CNT_W_DEF  = 32;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        TRACKING = 2'd1,
        HOLD     = 2'd2
    } state_t;

    function automatic int slice_w(input int slices);
        return $clog2(slices);
    endfunction

endpackage

// File: rtl/hall_slice_tracker_if.sv
// hall_slice_tracker_if: Hall period input and slice-position outputs of the slice tracker.
interface hall_slice_tracker_if #(
    parameter int SLICES = hall_pkg::SLICES_DEF,
    parameter int CNT_W  = hall_pkg::CNT_W_DEF
);
    localparam int S = hall_pkg::slice_w(SLICES);

    logic [CNT_W-1:0] speed_data;
    logic             start_of_turn;
    logic [S-1:0]     slice_offset;
    logic [S-1:0]     slice_cnt;
    logic             position_sync;
    logic             locked;
    logic             turn_overrun;

    modport master (
        output speed_data, start_of_turn, slice_offset,
        input  slice_cnt, position_sync, locked, turn_overrun
    );

    modport slave (
        input  speed_data, start_of_turn, slice_offset,
        output slice_cnt, position_sync, locked, turn_overrun
    );

endinterface

// File: rtl/hall_period_filter.sv
// hall_period_filter: latches the Hall period on start_of_turn and splits it into base/remainder.
// Defining HALL_SLICE_TRACKER_FILTER_EN smooths the latched period as (3*prev + new) / 4.
module hall_period_filter
    import hall_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int S     = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
`ifdef HALL_SLICE_TRACKER_FILTER_EN
    input  logic               primed,
`endif
    input  logic [CNT_W-1:0]   speed_data,
    output logic               valid,
    output logic [CNT_W-S-1:0] base,
    output logic [S-1:0]       rem,
    output logic [CNT_W-1:0]   period
);

    logic [CNT_W-1:0] cand;
    logic [CNT_W-1:0] per_q;

`ifdef HALL_SLICE_TRACKER_FILTER_EN
    logic [CNT_W+1:0] mix;
    logic [CNT_W-1:0] raw_q;

    // first sample after losing lock has no history worth blending with
    assign mix  = ({2'b00, per_q} << 1) + {2'b00, per_q} + {2'b00, speed_data};
    assign cand = primed ? CNT_W'(mix >> 2) : speed_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            raw_q <= '0;
        end else if (load && valid) begin
            raw_q <= speed_data;
        end
    end

    assign period = raw_q;
`else
    assign cand   = speed_data;
    assign period = per_q;
`endif

    assign valid = |cand[CNT_W-1:S];

    always_ff @(posedge clk) begin
        if (rst) begin
            per_q <= '0;
        end else if (load && valid) begin
            per_q <= cand;
        end
    end

    assign base = per_q[CNT_W-1:S];
    assign rem  = per_q[S-1:0];

endmodule

// File: rtl/hall_slice_tracker.sv
// hall_slice_tracker: turns the latched Hall period into SLICES evenly spaced slice strobes per turn.
// Optional IIR period smoothing is enabled by defining HALL_SLICE_TRACKER_FILTER_EN.
module hall_slice_tracker
    import hall_pkg::*;
#(
    parameter int SLICES    = SLICES_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int WDOG_MULT = 2
) (
    input logic                 clk,
    input logic                 rst,
    hall_slice_tracker_if.slave bus
);
    // state    | meaning
    // UNLOCKED | no valid period; slice_cnt frozen, no strobes
    // TRACKING | stepping through the slices of the latched period
    // HOLD     | all slices issued, waiting for the next start_of_turn

    localparam int S  = slice_w(SLICES);
    localparam int TW = CNT_W - S + 1;
    localparam int WW = CNT_W + 2;

    state_t             state_q, state_d;
    logic [TW-1:0]      tick_q, tick_d, len;
    logic [S-1:0]       frac_q, frac_d, frac_sum;
    logic [S-1:0]       slice_q, slice_d;
    logic [S-1:0]       done_q, done_d;
    logic [WW-1:0]      wdog_q, wdog_d, wdog_lim;
    logic               sync_q, sync_d;
    logic               ovr_q, ovr_d;
    logic               carry;
    logic               per_valid;
    logic [CNT_W-S-1:0] base;
    logic [S-1:0]       rem;
    logic [CNT_W-1:0]   period;

    hall_period_filter #(
        .CNT_W (CNT_W),
        .S     (S)
    ) u_filter (
        .clk        (clk),
        .rst        (rst),
        .load       (bus.start_of_turn),
`ifdef HALL_SLICE_TRACKER_FILTER_EN
        .primed     (state_q != UNLOCKED),
`endif
        .speed_data (bus.speed_data),
        .valid      (per_valid),
        .base       (base),
        .rem        (rem),
        .period     (period)
    );

    // fractional ticks spill into a slice whenever the accumulator wraps
    assign {carry, frac_sum} = {1'b0, frac_q} + {1'b0, rem};
    assign len      = {1'b0, base} + TW'(carry);
    assign wdog_lim = WW'(WDOG_MULT) * {2'b00, period};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= UNLOCKED;
            tick_q  <= '0;
            frac_q  <= '0;
            slice_q <= '0;
            done_q  <= '0;
            wdog_q  <= '0;
            sync_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            frac_q  <= frac_d;
            slice_q <= slice_d;
            done_q  <= done_d;
            wdog_q  <= wdog_d;
            sync_q  <= sync_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        frac_d  = frac_q;
        slice_d = slice_q;
        done_d  = done_q;
        wdog_d  = wdog_q;
        sync_d  = 1'b0;
        ovr_d   = 1'b0;
        if (bus.start_of_turn) begin
            if (per_valid) begin
                state_d = TRACKING;
                slice_d = bus.slice_offset;
                sync_d  = 1'b1;
                tick_d  = TW'(1);
                frac_d  = '0;
                done_d  = '0;
                wdog_d  = WW'(1);
            end else begin
                state_d = UNLOCKED;
            end
        end else if (state_q != UNLOCKED) begin
            wdog_d = (&wdog_q) ? wdog_q : wdog_q + 1'b1;
            if (wdog_q > wdog_lim) begin
                state_d = UNLOCKED;
            end else if (state_q == TRACKING) begin
                if (tick_q != len) begin
                    tick_d = tick_q + 1'b1;
                end else if (done_q == S'(SLICES - 1)) begin
                    state_d = HOLD;
                    ovr_d   = 1'b1;
                end else begin
                    tick_d  = TW'(1);
                    frac_d  = frac_sum;
                    slice_d = slice_q + 1'b1;
                    done_d  = done_q + 1'b1;
                    sync_d  = 1'b1;
                end
            end
        end
    end

    assign bus.slice_cnt     = slice_q;
    assign bus.position_sync = sync_q;
    assign bus.locked        = (state_q != UNLOCKED);
    assign bus.turn_overrun  = ovr_q;

endmodule
